dport_splitter: RTL
===================

Name: dport_splitter

Overview:
- Data-port interconnect between the merlin32i core data port and two data targets.
- Target 0 is the ssram; target 1 is an MMIO peripheral window.
- Routes each request by address decode.
- Tracks outstanding transactions in an order FIFO so responses return to the core strictly in request order, even when targets have different latencies.

Parameters:
C_M1_BASE, 32'h8000_0000, m1 window base
C_M1_MASK, 32'hF000_0000, m1 window mask; hit when (addr & mask) == base
C_M0_BASE, 32'h0000_0000, m0 window base (used only with the optional feature)
C_M0_MASK, 32'hF000_0000, m0 window mask (used only with the optional feature)
C_MAX_OUTSTANDING, 4, order FIFO depth; power of 2, minimum 2

Ports:
clk_i  in  1  clock, rising edge
resetb_i  in  1  asynchronous active-low reset
clk_en_i  in  1  clock enable; no state update or transfer when low
treqready_o  out  1  request accepted by splitter
treqvalid_i  in  1  core request valid
treqdvalid_i  in  1  request is a write (data valid)
treqsize_i  in  2  access size, passed through
treqaddr_i  in  32  byte address
treqdata_i  in  32  write data
trspready_i  in  1  core can accept response
trspvalid_o  out  1  response valid
trsprerr_o  out  1  read error
trspwerr_o  out  1  write error
trspdata_o  out  32  read data
m0reqready_i  in  1  target 0 ready
m0reqvalid_o  out  1  request valid to target 0
m0reqdvalid_o / m0reqsize_o / m0reqaddr_o / m0reqdata_o  out  1/2/32/32  broadcast copies of treq* fields
m0rspready_o  out  1  response ready to target 0
m0rspvalid_i / m0rsprerr_i / m0rspwerr_i / m0rspdata_i  in  1/1/1/32  target 0 response
m1*  identical set for target 1

Behaviour:
- Clock and reset: one clock (clk_i). resetb_i is an asynchronous active-low reset that clears all state.
- Run flag: registered flag `run`, cleared by reset, set on the first enabled edge after resetb_i is high. All valid/ready outputs are 0 while run=0.
- Decode: sel1 = ((treqaddr_i & C_M1_MASK) == C_M1_BASE); otherwise target 0.
- Request path (combinational, zero added latency):
  - mXreqvalid_o = run & clk_en_i & treqvalid_i & (sel==X) & ~full.
  - treqready_o = run & clk_en_i & ~full & mXreqready_i of the selected target.
  - Payload fields go to both targets unqualified.
- Accept and push: accept = treqvalid_i & treqready_o. On accept, push {dvalid, target id} into the order FIFO.
- Response path:
  - head = FIFO head entry.
  - trspvalid_o = ~empty & m[head]rspvalid_i.
  - m[head]rspready_o = ~empty & trspready_i & run & clk_en_i; the non-head target's rspready is 0.
  - trsp data/err are muxed from the head target; all 0 when empty.
  - Pop when trspvalid_o & trspready_i.
- FIFO: read/write pointers of log2(depth) bits; count of log2(depth)+1 bits; pointers wrap naturally.
  - Push and pop in the same cycle leave count unchanged.
  - When full, requests stall even if a pop occurs that cycle (no response-to-request combinational path).
- Empty: trspvalid_o = 0 and both rspready = 0. A target response with nothing outstanding stays stalled and is never forwarded.
- Out-of-order targets: a response from the non-head target is held (rspready=0) until its entry reaches the head.
- Reset mid-operation: pointers, count and run clear immediately; outstanding transactions are discarded; targets are assumed reset together.
- Reset values: all outputs 0.

Optional Feature:
- Macro: DPORT_SPLIT_DECERR_EN.
- Enabled:
  - m0 hit additionally requires (addr & C_M0_MASK) == C_M0_BASE.
  - An address matching neither window is accepted with no target request (treqready_o = ~full); its FIFO entry is tagged as an error.
  - At the head, the splitter itself drives trspvalid_o=1, trsprerr_o=~dvalid, trspwerr_o=dvalid, trspdata_o=0, and pops on trspready_i.
  - FIFO entry is 3 bits.
- Disabled: every non-m1 address goes to m0; the error path is absent; FIFO entry is 2 bits.

Test Plan:
1. Reset released, read addr 32'h0000_0010, m0 responds data 32'hDEAD_BEEF after 1 cycle -> m0reqvalid_o=1, m1reqvalid_o=0; trspdata_o=32'hDEAD_BEEF, trsprerr_o=0; FIFO returns to empty.
2. Read m1 (32'h8000_0000) with 5-cycle latency, then read m0 (32'h0000_0004) with 1-cycle latency -> m0 response held with m0rspready_o=0 until the m1 response pops; core sees m1 data first, then m0 data.
3. Issue 4 back-to-back m0 reads with m0rspvalid_i=0 -> treqready_o=0 on the 5th request. Assert one pop that cycle -> still stalled. Next cycle -> 5th accepted.
4. trspready_i=0 for 3 cycles with m0rspvalid_i=1 -> trspvalid_o stays 1, data stable, no pop; pops on the first cycle trspready_i=1.
5. resetb_i low for 1 cycle with 2 outstanding -> all outputs 0 immediately; count 0; after release the first new request is accepted only after run sets.
6. With DPORT_SPLIT_DECERR_EN and C_M0_MASK=32'hF000_0000: write to 32'h4000_0000 -> no target valid; trspvalid_o=1, trspwerr_o=1, trsprerr_o=0, trspdata_o=0. A read there -> trsprerr_o=1.

Source files
------------

// File: rtl/dport_splitter.sv
// Data-port splitter: routes core requests to ssram (m0) or an MMIO window (m1), returning
// responses in request order via an order FIFO. DPORT_SPLIT_DECERR_EN adds a decode-error responder.
module dport_splitter #(
  parameter logic [31:0] C_M1_BASE         = 32'h8000_0000,
  parameter logic [31:0] C_M1_MASK         = 32'hF000_0000,
  parameter logic [31:0] C_M0_BASE         = 32'h0000_0000,
  parameter logic [31:0] C_M0_MASK         = 32'hF000_0000,
  parameter int          C_MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [1:0]  treqsize_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic        trsprerr_o,
  output logic        trspwerr_o,
  output logic [31:0] trspdata_o,
  input  logic        m0reqready_i,
  output logic        m0reqvalid_o,
  output logic        m0reqdvalid_o,
  output logic [1:0]  m0reqsize_o,
  output logic [31:0] m0reqaddr_o,
  output logic [31:0] m0reqdata_o,
  output logic        m0rspready_o,
  input  logic        m0rspvalid_i,
  input  logic        m0rsprerr_i,
  input  logic        m0rspwerr_i,
  input  logic [31:0] m0rspdata_i,
  input  logic        m1reqready_i,
  output logic        m1reqvalid_o,
  output logic        m1reqdvalid_o,
  output logic [1:0]  m1reqsize_o,
  output logic [31:0] m1reqaddr_o,
  output logic [31:0] m1reqdata_o,
  output logic        m1rspready_o,
  input  logic        m1rspvalid_i,
  input  logic        m1rsprerr_i,
  input  logic        m1rspwerr_i,
  input  logic [31:0] m1rspdata_i
);

  localparam int C_PTR_W = $clog2(C_MAX_OUTSTANDING);
  localparam int C_CNT_W = C_PTR_W + 1;
`ifdef DPORT_SPLIT_DECERR_EN
  localparam int C_ENT_W  = 3;
  localparam bit C_DECERR = 1'b1;
`else
  localparam int C_ENT_W  = 2;
  localparam bit C_DECERR = 1'b0;
`endif

  logic               r_run;
  logic [C_PTR_W-1:0] r_wptr;
  logic [C_PTR_W-1:0] r_rptr;
  logic [C_CNT_W-1:0] r_count;
  logic [C_ENT_W-1:0] r_fifo [C_MAX_OUTSTANDING];

  logic               w_en;
  logic               w_full;
  logic               w_empty;
  logic               w_sel1;
  logic               w_sel0;
  logic               w_m0_hit;
  logic               w_decerr;
  logic               w_push;
  logic               w_pop;
  logic [C_ENT_W-1:0] w_push_ent;
  logic [C_ENT_W-1:0] w_head;
  logic               w_head_tgt;
  logic               w_head_dv;
  logic               w_head_err;

  assign w_en    = r_run & clk_en_i;
  assign w_full  = (r_count == C_CNT_W'(C_MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // Without the error path every non-m1 address falls through to m0.
  assign w_sel1   = ((treqaddr_i & C_M1_MASK) == C_M1_BASE);
  assign w_m0_hit = ((treqaddr_i & C_M0_MASK) == C_M0_BASE);
  assign w_decerr = C_DECERR & ~w_sel1 & ~w_m0_hit;
  assign w_sel0   = ~w_sel1 & ~w_decerr;

  assign m0reqvalid_o = w_en & treqvalid_i & w_sel0 & ~w_full;
  assign m1reqvalid_o = w_en & treqvalid_i & w_sel1 & ~w_full;
  assign treqready_o  = w_en & ~w_full &
                        ((w_sel1 & m1reqready_i) | (w_sel0 & m0reqready_i) | w_decerr);

  assign m0reqdvalid_o = treqdvalid_i;
  assign m0reqsize_o   = treqsize_i;
  assign m0reqaddr_o   = treqaddr_i;
  assign m0reqdata_o   = treqdata_i;
  assign m1reqdvalid_o = treqdvalid_i;
  assign m1reqsize_o   = treqsize_i;
  assign m1reqaddr_o   = treqaddr_i;
  assign m1reqdata_o   = treqdata_i;

  assign w_push = treqvalid_i & treqready_o;

  // Entry layout: [0] target id, [1] write flag, [2] decode error (when present).
`ifdef DPORT_SPLIT_DECERR_EN
  assign w_push_ent = {w_decerr, treqdvalid_i, w_sel1};
  assign w_head_err = w_head[2];
`else
  assign w_push_ent = {treqdvalid_i, w_sel1};
  assign w_head_err = 1'b0;
`endif

  assign w_head     = r_fifo[r_rptr];
  assign w_head_tgt = w_head[0];
  assign w_head_dv  = w_head[1];

  always_comb begin
    trspvalid_o  = 1'b0;
    trsprerr_o   = 1'b0;
    trspwerr_o   = 1'b0;
    trspdata_o   = '0;
    m0rspready_o = 1'b0;
    m1rspready_o = 1'b0;
    if (!w_empty) begin
      if (w_head_err) begin
        trspvalid_o = 1'b1;
        trsprerr_o  = ~w_head_dv;
        trspwerr_o  = w_head_dv;
      end else if (w_head_tgt) begin
        trspvalid_o  = m1rspvalid_i;
        trsprerr_o   = m1rsprerr_i;
        trspwerr_o   = m1rspwerr_i;
        trspdata_o   = m1rspdata_i;
        m1rspready_o = trspready_i & w_en;
      end else begin
        trspvalid_o  = m0rspvalid_i;
        trsprerr_o   = m0rsprerr_i;
        trspwerr_o   = m0rspwerr_i;
        trspdata_o   = m0rspdata_i;
        m0rspready_o = trspready_i & w_en;
      end
    end
  end

  assign w_pop = trspvalid_o & trspready_i & w_en;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_run   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clk_en_i) begin
      r_run <= 1'b1;
      if (w_push) r_wptr <= r_wptr + C_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + C_PTR_W'(1);
      r_count <= r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_push_ent;
  end

endmodule
